// File: rtl/sram_23k640_pkg.sv
// ---------------------------------------------------------------------------
// sram_23k640_pkg
// Shared definitions for the 23K640 SPI SRAM responder controller:
//   - SPI opcodes for byte-mode READ / WRITE
//   - frame length in bits (opcode + 16-bit address + data byte)
//   - controller FSM state encoding
//   - helper that assembles the 32-bit frame shifted out on SI
// ---------------------------------------------------------------------------
package sram_23k640_pkg;

   localparam logic [7:0] OP_READ   = 8'h03;
   localparam logic [7:0] OP_WRITE  = 8'h02;
   localparam int         FRAME_LEN = 32;
   localparam int         CLK_DIV_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      SHIFT,
      TRAIL,
      RECOVER
   } state_t;

   // Read frames send a zero byte in the data slot while the device drives SO.
   function automatic logic [31:0] build_frame(input logic       rd_n_wr,
                                               input logic [15:0] addr,
                                               input logic [7:0]  wdata);
      logic [7:0] opcode;
      logic [7:0] data;
      opcode = rd_n_wr ? OP_READ : OP_WRITE;
      data   = rd_n_wr ? 8'h00 : wdata;
      return {opcode, addr, data};
   endfunction

endpackage

// File: rtl/sram_23k640_sck_gen.sv
// ---------------------------------------------------------------------------
// sram_23k640_sck_gen
// SPI clock divider: while enabled, toggles a registered SCK every p_clk_div
// i_clk cycles. When disabled the divider is held at zero and SCK low, so the
// first enabled cycle always starts a fresh low half-period.
// Ports:
//   i_clk   clock
//   i_rst   asynchronous active-high reset
//   i_en    run the divider (SHIFT phase)
//   o_sck   registered SPI clock, idles low
//   o_rise  strobe: SCK goes high at the next i_clk edge
//   o_fall  strobe: SCK goes low at the next i_clk edge
// ---------------------------------------------------------------------------
module sram_23k640_sck_gen
   import sram_23k640_pkg::*;
#(
   parameter int p_clk_div = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   output logic o_sck,
   output logic o_rise,
   output logic o_fall
);

   localparam logic [CLK_DIV_W-1:0] c_div_last = CLK_DIV_W'(p_clk_div - 1);

   logic [CLK_DIV_W-1:0] cnt_q;
   logic [CLK_DIV_W-1:0] cnt_d;
   logic                 sck_q;
   logic                 sck_d;
   logic                 wrap;

   // Half-period counter 0..D-1; SCK toggles when it wraps.
   always_comb begin
      wrap  = i_en && (cnt_q == c_div_last);
      cnt_d = '0;
      sck_d = 1'b0;
      if (i_en) begin
         cnt_d = wrap ? '0 : cnt_q + 1'b1;
         sck_d = wrap ? ~sck_q : sck_q;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
         sck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sck_q <= sck_d;
      end
   end

   assign o_sck  = sck_q;
   assign o_rise = wrap & ~sck_q;
   assign o_fall = wrap & sck_q;

endmodule

// File: rtl/sram_23k640_ctrl.sv
// ---------------------------------------------------------------------------
// sram_23k640_ctrl
// Responder for one 23K640 SPI SRAM. Accepts a single-byte read/write request
// with a valid/accept handshake, runs one SPI mode-0 byte-mode frame
// (CMD, ADDR16, DATA8), then pulses ready (with read data for reads).
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_valid / o_accept    request handshake (accept is combinational in IDLE)
//   i_rd_n_wr, i_addr,    request fields, captured only in the accept cycle
//   i_wdata
//   o_ready               1-cycle pulse when the frame has completed
//   o_rdata               last byte read; changes only on read completion
//   o_cs_n, o_sck, o_si   registered SPI outputs to the device
//   i_so                  SPI data from the device
// Phase lengths, D = p_clk_div: LEAD D cycles (CS setup), SHIFT 64 SCK
// half-periods, TRAIL D cycles (CS hold), RECOVER D cycles (CS high).
// ---------------------------------------------------------------------------
module sram_23k640_ctrl
   import sram_23k640_pkg::*;
#(
   parameter int p_clk_div = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   output logic        o_accept,
   input  logic        i_rd_n_wr,
   input  logic [15:0] i_addr,
   input  logic [7:0]  i_wdata,
   output logic        o_ready,
   output logic [7:0]  o_rdata,
   output logic        o_cs_n,
   output logic        o_sck,
   output logic        o_si,
   input  logic        i_so
);

   localparam logic [CLK_DIV_W-1:0] c_div_last = CLK_DIV_W'(p_clk_div - 1);
   localparam logic [4:0]           c_bit_last = 5'(FRAME_LEN - 1);

   state_t               state_q,  state_d;
   logic [CLK_DIV_W-1:0] wait_q,   wait_d;
   logic [4:0]           bit_q,    bit_d;
   logic [31:0]          frame_q,  frame_d;
   logic [7:0]           rx_q,     rx_d;
   logic [7:0]           rdata_q,  rdata_d;
   logic                 rd_q,     rd_d;
   logic                 ready_q,  ready_d;
   logic                 cs_n_q,   cs_n_d;
   logic                 sample_q, sample_d;
   logic                 accept;
   logic                 sck_rise;
   logic                 sck_fall;

   sram_23k640_sck_gen #(
      .p_clk_div (p_clk_div)
   ) u_sck_gen (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (state_q == SHIFT),
      .o_sck  (o_sck),
      .o_rise (sck_rise),
      .o_fall (sck_fall)
   );

   // Next-state and datapath. SI is the frame MSB, so shifting the frame on
   // each SCK fall moves SI exactly when SCK drops. SO is sampled at the end
   // of the first SCK-high cycle (sample_q), giving the device a full
   // half-period after its falling-edge update. All 32 SO bits are shifted
   // into rx, so only the data byte remains there at the end of SHIFT.
   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      bit_d    = bit_q;
      frame_d  = frame_q;
      rx_d     = rx_q;
      rdata_d  = rdata_q;
      rd_d     = rd_q;
      ready_d  = 1'b0;
      accept   = 1'b0;
      sample_d = sck_rise;

      if (sample_q) begin
         rx_d = {rx_q[6:0], i_so};
      end

      case (state_q)
         IDLE: begin
            if (i_valid) begin
               accept  = 1'b1;
               frame_d = build_frame(i_rd_n_wr, i_addr, i_wdata);
               rd_d    = i_rd_n_wr;
               wait_d  = '0;
               bit_d   = '0;
               state_d = LEAD;
            end
         end
         LEAD: begin
            if (wait_q == c_div_last) begin
               wait_d  = '0;
               state_d = SHIFT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         SHIFT: begin
            if (sck_fall) begin
               frame_d = {frame_q[30:0], 1'b0};
               if (bit_q == c_bit_last) begin
                  state_d = TRAIL;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         TRAIL: begin
            if (wait_q == c_div_last) begin
               wait_d  = '0;
               ready_d = 1'b1;
               if (rd_q) begin
                  rdata_d = rx_q;
               end
               state_d = RECOVER;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         RECOVER: begin
            if (wait_q == c_div_last) begin
               wait_d  = '0;
               state_d = IDLE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Chip select follows the next state so it is registered yet lands in
      // the first cycle of LEAD and releases in the first cycle of RECOVER.
      cs_n_d = !((state_d == LEAD) || (state_d == SHIFT) || (state_d == TRAIL));
   end

   // State and datapath registers; reset aborts any frame immediately.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= IDLE;
         wait_q   <= '0;
         bit_q    <= '0;
         frame_q  <= '0;
         rx_q     <= '0;
         rdata_q  <= '0;
         rd_q     <= 1'b0;
         ready_q  <= 1'b0;
         cs_n_q   <= 1'b1;
         sample_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         bit_q    <= bit_d;
         frame_q  <= frame_d;
         rx_q     <= rx_d;
         rdata_q  <= rdata_d;
         rd_q     <= rd_d;
         ready_q  <= ready_d;
         cs_n_q   <= cs_n_d;
         sample_q <= sample_d;
      end
   end

   assign o_accept = accept & ~i_rst;
   assign o_ready  = ready_q;
   assign o_rdata  = rdata_q;
   assign o_cs_n   = cs_n_q;
   assign o_si     = frame_q[31];

endmodule

// File: tb/tb_sram_23k640_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_23k640_ctrl
// Directed bench for sram_23k640_ctrl with a behavioural 23K640 model.
// DUT A runs with p_clk_div=2, DUT B with p_clk_div=5. Cycle numbers are
// counted from the accept cycle (cycle 0).
// ---------------------------------------------------------------------------
module tb_sram_23k640_ctrl;

   logic        i_clk;
   logic        i_rst;

   logic        valid, rd_n_wr, accept, ready, cs_n, sck, si, so;
   logic [15:0] addr;
   logic [7:0]  wdata, rdata;

   logic        valid_b, rd_n_wr_b, accept_b, ready_b, cs_n_b, sck_b, si_b, so_b;
   logic [15:0] addr_b;
   logic [7:0]  wdata_b, rdata_b;

   int          checks = 0;
   int          errors = 0;

   int          res_ready_k, res_cs_first, res_cs_last, res_cs_cnt;
   logic [7:0]  res_rdata;

   logic [7:0]  mem_a [0:8191];
   logic [7:0]  sb    [0:8191];
   int          rise_a;
   logic [31:0] si_a;
   logic [7:0]  rd_op_a;
   logic [12:0] rd_ad_a;
   logic [7:0]  byte_a;

   int          rise_b;
   logic [31:0] si_bst;
   logic [7:0]  byte_b = 8'h96;

   sram_23k640_ctrl #(.p_clk_div(2)) dut_a (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(valid), .o_accept(accept),
      .i_rd_n_wr(rd_n_wr), .i_addr(addr), .i_wdata(wdata), .o_ready(ready),
      .o_rdata(rdata), .o_cs_n(cs_n), .o_sck(sck), .o_si(si), .i_so(so)
   );

   sram_23k640_ctrl #(.p_clk_div(5)) dut_b (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(valid_b), .o_accept(accept_b),
      .i_rd_n_wr(rd_n_wr_b), .i_addr(addr_b), .i_wdata(wdata_b), .o_ready(ready_b),
      .o_rdata(rdata_b), .o_cs_n(cs_n_b), .o_sck(sck_b), .o_si(si_b), .i_so(so_b)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Device model A: full 8 KiB memory, mode 0 (sample SI on rise, drive SO on fall).
   always @(negedge cs_n) begin
      rise_a = 0;
      si_a   = '0;
   end

   always @(posedge sck) begin
      if (cs_n === 1'b0) begin
         si_a = {si_a[30:0], si};
         rise_a++;
         if (rise_a == 24) begin
            rd_op_a = si_a[23:16];
            rd_ad_a = si_a[12:0];
         end
         if (rise_a == 32 && si_a[31:24] == 8'h02) mem_a[si_a[20:8]] = si_a[7:0];
      end
   end

   always @(negedge sck) begin
      if (cs_n === 1'b0 && rise_a >= 24 && rise_a < 32 && rd_op_a == 8'h03) begin
         byte_a = mem_a[rd_ad_a];
         so     = byte_a[31 - rise_a];
      end
   end

   // Device model B: every read returns byte_b.
   always @(negedge cs_n_b) begin
      rise_b = 0;
      si_bst = '0;
   end

   always @(posedge sck_b) begin
      if (cs_n_b === 1'b0) begin
         si_bst = {si_bst[30:0], si_b};
         rise_b++;
      end
   end

   always @(negedge sck_b) begin
      if (cs_n_b === 1'b0 && rise_b >= 24 && rise_b < 32) so_b = byte_b[31 - rise_b];
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: time limit reached, got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Runs one request on DUT A and records ready cycle, CS-low window and read data.
   // Request inputs are scrambled right after the accept cycle.
   task automatic applyStimulus(input logic t_rd, input logic [15:0] t_addr, input logic [7:0] t_wd);
      bit got_acc;
      res_ready_k  = -1;
      res_cs_first = -1;
      res_cs_last  = -1;
      res_cs_cnt   = 0;
      @(posedge i_clk); #1;
      valid   = 1'b1;
      rd_n_wr = t_rd;
      addr    = t_addr;
      wdata   = t_wd;
      got_acc = 1'b0;
      for (int t = 0; t < 200 && !got_acc; t++) begin
         @(negedge i_clk);
         if (accept) got_acc = 1'b1;
      end
      if (!got_acc) begin
         checkOutput("accept_timeout", 32'd0, 32'd1);
         valid = 1'b0;
         return;
      end
      @(posedge i_clk); #1;
      valid   = 1'b0;
      rd_n_wr = ~t_rd;
      addr    = ~t_addr;
      wdata   = ~t_wd;
      for (int k = 1; k < 2000 && res_ready_k < 0; k++) begin
         @(negedge i_clk);
         if (!cs_n) begin
            res_cs_cnt++;
            if (res_cs_first < 0) res_cs_first = k;
            res_cs_last = k;
         end
         if (ready) begin
            res_ready_k = k;
            res_rdata   = rdata;
         end
      end
      if (res_ready_k < 0) checkOutput("ready_timeout", 32'd0, 32'd1);
      repeat (3) @(negedge i_clk);
   endtask

   initial begin
      int          acc, rdy, gap, acc2_k, bad, prev, nrise, first_rise, last_rise, bad_per, bad_hi, rdyk;
      logic [7:0]  rdat;
      logic        t_rd;
      logic [15:0] t_addr;
      logic [7:0]  t_wd;

      for (int i = 0; i < 8192; i++) begin
         mem_a[i] = 8'(i) ^ 8'h5A;
         sb[i]    = 8'(i) ^ 8'h5A;
      end
      so = 1'b0; so_b = 1'b0;
      valid = 1'b0; rd_n_wr = 1'b0; addr = '0; wdata = '0;
      valid_b = 1'b0; rd_n_wr_b = 1'b0; addr_b = '0; wdata_b = '0;
      i_rst = 1'b1;

      // Reset values
      repeat (3) @(negedge i_clk);
      checkOutput("rst_accept", 32'(accept), 32'd0);
      checkOutput("rst_ready",  32'(ready),  32'd0);
      checkOutput("rst_rdata",  32'(rdata),  32'd0);
      checkOutput("rst_cs_n",   32'(cs_n),   32'd1);
      checkOutput("rst_sck",    32'(sck),    32'd0);
      checkOutput("rst_si",     32'(si),     32'd0);
      @(posedge i_clk); #1;
      i_rst = 1'b0;

      // 1: write A5 to 0123
      applyStimulus(1'b0, 16'h0123, 8'hA5);
      sb[13'h0123] = 8'hA5;
      checkOutput("t1_si_stream", si_a, 32'h020123A5);
      checkOutput("t1_sck_rises", rise_a, 32);
      checkOutput("t1_ready_cyc", res_ready_k, 133);
      checkOutput("t1_cs_first",  res_cs_first, 1);
      checkOutput("t1_cs_last",   res_cs_last, 132);
      checkOutput("t1_cs_cnt",    res_cs_cnt, 132);
      checkOutput("t1_rdata",     32'(res_rdata), 32'h00);
      checkOutput("t1_mem",       32'(mem_a[13'h0123]), 32'hA5);

      // 2: read 1FFF holding 3C
      mem_a[13'h1FFF] = 8'h3C;
      sb[13'h1FFF]    = 8'h3C;
      applyStimulus(1'b1, 16'h1FFF, 8'hEE);
      checkOutput("t2_si_stream", si_a, 32'h031FFF00);
      checkOutput("t2_ready_cyc", res_ready_k, 133);
      checkOutput("t2_rdata",     32'(res_rdata), 32'h3C);
      repeat (10) @(negedge i_clk);
      checkOutput("t2_rdata_held", 32'(rdata), 32'h3C);

      // 3: valid held across two write requests
      @(posedge i_clk); #1;
      valid = 1'b1; rd_n_wr = 1'b0; addr = 16'h0456; wdata = 8'h3E;
      acc = 0; rdy = 0; gap = 0; acc2_k = -1;
      for (int k = 0; k < 600 && rdy < 2; k++) begin
         @(negedge i_clk);
         if (ready) rdy++;
         if (rdy == 1 && acc == 1 && cs_n) gap++;
         if (accept) begin
            acc++;
            if (acc == 2) begin
               acc2_k = k;
               @(posedge i_clk); #1;
               valid = 1'b0;
            end
         end
      end
      valid = 1'b0;
      sb[13'h0456] = 8'h3E;
      checkOutput("t3_accepts",   acc, 2);
      checkOutput("t3_readies",   rdy, 2);
      checkOutput("t3_acc2_cyc",  acc2_k, 135);
      checkOutput("t3_cs_gap_ge2", 32'(gap >= 2), 32'd1);
      checkOutput("t3_mem",       32'(mem_a[13'h0456]), 32'h3E);
      checkOutput("t3_rdata_stable", 32'(rdata), 32'h3C);
      repeat (4) @(negedge i_clk);

      // 4: reset during SHIFT, then a full write
      @(posedge i_clk); #1;
      valid = 1'b1; rd_n_wr = 1'b0; addr = 16'h0055; wdata = 8'h77;
      @(negedge i_clk);
      checkOutput("t4_accept", 32'(accept), 32'd1);
      @(posedge i_clk); #1;
      valid = 1'b0;
      bad = 0;
      for (int k = 1; k < 40; k++) begin
         @(negedge i_clk);
         if (ready) bad++;
      end
      checkOutput("t4_cs_low_before", 32'(cs_n), 32'd0);
      @(posedge i_clk); #1;
      i_rst = 1'b1;
      #1;
      checkOutput("t4_rst_cs_n", 32'(cs_n), 32'd1);
      checkOutput("t4_rst_sck",  32'(sck),  32'd0);
      repeat (3) begin
         @(negedge i_clk);
         if (ready) bad++;
      end
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      repeat (3) begin
         @(negedge i_clk);
         if (ready) bad++;
      end
      checkOutput("t4_no_ready", bad, 0);
      checkOutput("t4_no_write", 32'(mem_a[13'h0055]), 32'h0F);
      applyStimulus(1'b0, 16'h0001, 8'hC3);
      sb[13'h0001] = 8'hC3;
      checkOutput("t4_si_stream", si_a, 32'h020001C3);
      checkOutput("t4_ready_cyc", res_ready_k, 133);
      checkOutput("t4_mem",       32'(mem_a[13'h0001]), 32'hC3);

      // 5: DUT B, D=5 read
      @(posedge i_clk); #1;
      valid_b = 1'b1; rd_n_wr_b = 1'b1; addr_b = 16'h0ABC; wdata_b = 8'hFF;
      @(negedge i_clk);
      checkOutput("t5_accept", 32'(accept_b), 32'd1);
      @(posedge i_clk); #1;
      valid_b = 1'b0;
      prev = 0; nrise = 0; first_rise = -1; last_rise = -1; bad_per = 0; bad_hi = 0; rdyk = -1;
      rdat = 8'h00;
      for (int k = 1; k < 1000 && rdyk < 0; k++) begin
         @(negedge i_clk);
         if (sck_b && prev == 0) begin
            nrise++;
            if (first_rise < 0) first_rise = k;
            else if (k - last_rise != 10) bad_per++;
            last_rise = k;
         end
         if (!sck_b && prev == 1 && k - last_rise != 5) bad_hi++;
         prev = int'(sck_b);
         if (ready_b) begin
            rdyk = k;
            rdat = rdata_b;
         end
      end
      checkOutput("t5_first_rise", first_rise, 11);
      checkOutput("t5_rises",      nrise, 32);
      checkOutput("t5_period",     bad_per, 0);
      checkOutput("t5_high_width", bad_hi, 0);
      checkOutput("t5_ready_cyc",  rdyk, 331);
      checkOutput("t5_rdata",      32'(rdat), 32'h96);
      checkOutput("t5_si_stream",  si_bst, 32'h030ABC00);

      // 6: random mixed traffic over eight aliased locations
      for (int n = 0; n < 200; n++) begin
         repeat ($urandom_range(0, 3)) @(posedge i_clk);
         t_rd   = 1'($urandom_range(0, 1));
         t_addr = 16'($urandom) & 16'hE007;
         t_wd   = 8'($urandom);
         applyStimulus(t_rd, t_addr, t_wd);
         if (t_rd) checkOutput("t6_rd_data", 32'(res_rdata), 32'(sb[t_addr[12:0]]));
         else      sb[t_addr[12:0]] = t_wd;
      end
      for (int i = 0; i < 8; i++) begin
         checkOutput("t6_mem_final", 32'(mem_a[i]), 32'(sb[i]));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
